timerio: RTL and testbench
==========================

# timerio

Programmable 16-bit interval timer that responds to CPU bus cycles, sitting alongside the other I/O responders in the $E6xx window (decoded at $E6B0–$E6B7 by the top level). It answers byte-wide reads and writes through eight registers, counts down from a reload value at a prescaled rate, and raises an overflow flag that drives the shared interrupt line. It lets firmware get periodic or one-shot timing without polling loops.

## Interface
- PRESC_DEFAULT, 8'd0, reset value of the PRESC register

- clk  in  1  system (CPU) clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- irq  out  1  interrupt request, level, = STATUS.OVF & CTRL.IRQEN
- AD  in  3  register offset
- DI  in  8  write data from CPU
- DO  out  8  read data to CPU, combinational from AD and registers
- rw  in  1  1 = read, 0 = write
- cs  in  1  chip select (decoded address & vma)

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 IRQEN, bit2 ONESHOT; bits 7:3 read 0.
  - 1 STATUS: bit0 OVF (write 1 to clear), bit1 RUN (mirror of EN, read-only).
  - 2 PRESC.
  - 3 RELOAD_H: write goes to the holding byte; read returns committed reload[15:8].
  - 4 RELOAD_L: write commits {holding, DI} to reload atomically.
  - 5 COUNT_H: read returns count[15:8] and latches count[7:0] into the shadow.
  - 6 COUNT_L: read returns the shadow.
  - 7 reads 0; writes are ignored.
- Write strobe = cs & !rw sampled at the clk edge. Read side effect (the COUNT_H latch) = cs & rw & AD==5 at the clk edge.
- Reset:
  - CTRL, STATUS, reload, holding, count, shadow and prescaler counter all go to 0; PRESC goes to PRESC_DEFAULT.
  - irq=0. DO=0 for every offset except 2, which reads PRESC_DEFAULT.
- EN 0→1 via a CTRL write: count←reload, prescaler counter←0. No tick occurs on that edge.
- While EN=1, each edge:
  - If prescaler counter == PRESC, a tick occurs and the prescaler counter←0; otherwise the prescaler counter increments.
- On a tick:
  - count≠0: count←count−1.
  - count==0: OVF←1 and count←reload. If ONESHOT=1, EN←0.
- EN=0 freezes count and the prescaler counter. Writing EN=1 while already 1 does not reload.
- Arithmetic is modulo 2^16. Reload=0 with PRESC=0 gives OVF every clk.
- Simultaneous events:
  - A CTRL write clearing EN on a tick edge: the write wins; no decrement and no OVF.
  - Write-1-to-clear OVF on the same edge as a new overflow: OVF stays 1.
  - A RELOAD_L commit on an overflow edge: count loads the old reload; the new value applies from the next overflow.
  - A one-shot overflow and a CTRL write with EN=1 on the same edge: the write wins, and the timer rearms.
- rst asserted mid-count aborts immediately; the state equals post-reset on the next edge.

## Timing
- Register writes are visible on DO the cycle after the write edge. Reads have zero wait states.
- With EN set at edge E0, the first OVF appears after edge E0 + (RELOAD+1)·(PRESC+1).
- Subsequent periodic overflows are (RELOAD+1)·(PRESC+1) clks apart.
- irq rises in the same cycle OVF becomes 1 and falls the cycle after OVF is cleared or IRQEN is written 0.
- The COUNT_H→COUNT_L pair is coherent if COUNT_L is read any time after COUNT_H, until the next COUNT_H read.

## Structure
- Shared package holds:
  - register offsets: TMR_CTRL=0 through TMR_COUNT_L=6;
  - CTRL bit indices: EN=0, IRQEN=1, ONESHOT=2;
  - STATUS bit indices: OVF=0, RUN=1.
- One natural sub-module, timer_prescaler: inputs clk, rst, clear, en, PRESC; output a one-clk tick pulse.
- Bus decode, registers and the down-counter stay in timerio.

## Test plan
- Reset: assert rst, then read offsets 0–7 → 00,00,PRESC_DEFAULT,00,00,00,00,00; irq=0.
- Periodic: RELOAD=0x0003, PRESC=0, CTRL=0x03 → OVF and irq rise exactly 4 clks after the CTRL write edge, then every 4 clks. Writing STATUS=0x01 drops irq the next cycle.
- Prescale/one-shot: RELOAD=0x0001, PRESC=2, CTRL=0x05 → OVF after 6 clks, EN reads 0, count stays at 0x0001, and no further OVF occurs.
- Atomic reload: with the timer running, write RELOAD_H=0x12 → reload readback is unchanged; write RELOAD_L=0x34 → reload reads 0x1234, and the period after the next overflow is 0x1235 clks.
- Coherent read: count=0x0100 decrementing every clk; read COUNT_H → 0x01, then COUNT_L three cycles later → 0x00 (shadow), not the live low byte.
- Collision: schedule a W1C on STATUS on the overflow edge → OVF remains 1. Assert rst mid-count → all registers read as at reset on the next cycle.

Source files
------------

// File: rtl/timerio_pkg.sv
// Shared register offsets and bit positions for the timerio interval timer.
package timerio_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_STATUS   = 3'd1;
    localparam logic [2:0] TMR_PRESC    = 3'd2;
    localparam logic [2:0] TMR_RELOAD_H = 3'd3;
    localparam logic [2:0] TMR_RELOAD_L = 3'd4;
    localparam logic [2:0] TMR_COUNT_H  = 3'd5;
    localparam logic [2:0] TMR_COUNT_L  = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQEN   = 1;
    localparam int CTRL_ONESHOT = 2;

    localparam int STAT_OVF = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/timerio_prescaler.sv
// Clock prescaler: emits a one-clk tick every (presc+1) enabled clocks.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] cnt;

    // clear restarts the phase on the enabling edge and suppresses any tick there
    assign tick = en & ~clear & (cnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (en) begin
            if (cnt == presc)
                cnt <= 8'd0;
            else
                cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timerio.sv
// Programmable 16-bit interval timer with byte-wide CPU register interface.
module timerio
    import timerio_pkg::*;
#(
    parameter logic [7:0] PRESC_DEFAULT = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs
);

    // Bus cycle: a write happens on any clk edge with cs=1, rw=0; reads are
    // combinational on DO and only the COUNT_H read has an edge side effect.
    logic        ctrl_en;
    logic        ctrl_irqen;
    logic        ctrl_oneshot;
    logic        ovf;
    logic [7:0]  presc;
    logic [7:0]  hold;
    logic [15:0] reload;
    logic [15:0] count;
    logic [7:0]  shadow;

    logic wr;
    logic wr_ctrl;
    logic wr_status;
    logic rd_count_h;
    logic en_rise;
    logic tick;
    logic tick_eff;
    logic ovf_event;

    assign wr         = cs & ~rw;
    assign wr_ctrl    = wr & (AD == TMR_CTRL);
    assign wr_status  = wr & (AD == TMR_STATUS);
    assign rd_count_h = cs & rw & (AD == TMR_COUNT_H);

    assign en_rise = wr_ctrl & DI[CTRL_EN] & ~ctrl_en;

    // A CTRL write clearing EN overrides a tick on the same edge
    assign tick_eff  = tick & ~(wr_ctrl & ~DI[CTRL_EN]);
    assign ovf_event = tick_eff & (count == 16'd0);

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (en_rise),
        .en    (ctrl_en),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en      <= 1'b0;
            ctrl_irqen   <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ovf          <= 1'b0;
            presc        <= PRESC_DEFAULT;
            hold         <= 8'd0;
            reload       <= 16'd0;
            count        <= 16'd0;
            shadow       <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en      <= DI[CTRL_EN];
                ctrl_irqen   <= DI[CTRL_IRQEN];
                ctrl_oneshot <= DI[CTRL_ONESHOT];
            end else if (ovf_event && ctrl_oneshot) begin
                ctrl_en <= 1'b0;
            end

            // New overflow beats a simultaneous write-1-to-clear
            ovf <= (ovf & ~(wr_status & DI[STAT_OVF])) | ovf_event;

            if (en_rise)
                count <= reload;
            else if (tick_eff)
                count <= (count == 16'd0) ? reload : count - 16'd1;

            if (wr && AD == TMR_PRESC)
                presc <= DI;
            if (wr && AD == TMR_RELOAD_H)
                hold <= DI;
            if (wr && AD == TMR_RELOAD_L)
                reload <= {hold, DI};

            if (rd_count_h)
                shadow <= count[7:0];
        end
    end

    assign irq = ovf & ctrl_irqen;

    always_comb begin
        DO = 8'd0;
        case (AD)
            TMR_CTRL: begin
                DO[CTRL_EN]      = ctrl_en;
                DO[CTRL_IRQEN]   = ctrl_irqen;
                DO[CTRL_ONESHOT] = ctrl_oneshot;
            end
            TMR_STATUS: begin
                DO[STAT_OVF] = ovf;
                DO[STAT_RUN] = ctrl_en;
            end
            TMR_PRESC:    DO = presc;
            TMR_RELOAD_H: DO = reload[15:8];
            TMR_RELOAD_L: DO = reload[7:0];
            TMR_COUNT_H:  DO = count[15:8];
            TMR_COUNT_L:  DO = shadow;
            default:      DO = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_timerio.sv
// Self-checking bench for timerio: directed register/timing steps plus randomized periodic runs.
module tb_timerio;

    localparam logic [7:0] PD = 8'h07;

    logic       clk;
    logic       rst;
    logic       irq;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    int n_checks = 0;
    int n_fail   = 0;

    timerio #(.PRESC_DEFAULT(PD)) dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(posedge clk);
        #1 cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1 d = DO;
        @(posedge clk);
        #1 cs = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b0; rw = 1'b1; AD = a;
        #1 d = DO;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_view(input string tag);
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 2) ? PD : 8'h00;
            peek(3'(i), d);
            check($sformatf("%s_reg%0d", tag, i), {8'h00, d}, {8'h00, exp});
        end
        check({tag, "_irq"}, {15'd0, irq}, 16'd0);
    endtask

    // reference: count value k clks after enabling, from tick arithmetic
    function automatic logic [15:0] model_count(input int r, input int p, input int k);
        int t;
        t = k / (p + 1);
        return 16'(r - (t % (r + 1)));
    endfunction

    // scoreboard of observed overflow intervals
    logic [15:0] exp_q[$];

    initial begin
        logic [7:0] d;
        int n;
        int gap;
        int r;
        int p;
        int per;
        logic [15:0] c;

        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_view("reset");

        // periodic: reload 3, presc 0, EN|IRQEN
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h03);
        bus_write(3'd2, 8'h00);
        bus_write(3'd0, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("per_irq_pre%0d", i), {15'd0, irq}, 16'd0);
        end
        @(posedge clk); #1;
        check("per_irq_first", {15'd0, irq}, 16'd1);
        peek(3'd1, d);
        check("per_status_first", {8'h00, d}, 16'h0003);
        bus_write(3'd1, 8'h01);
        check("per_irq_w1c", {15'd0, irq}, 16'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("per_irq_gap", {15'd0, irq}, 16'd0);
        end
        @(posedge clk); #1;
        check("per_irq_second", {15'd0, irq}, 16'd1);

        // collision: W1C lands exactly on the next overflow edge
        bus_write(3'd1, 8'h01);
        check("coll_cleared", {15'd0, irq}, 16'd0);
        repeat (2) @(posedge clk);
        bus_write(3'd1, 8'h01);
        peek(3'd1, d);
        check("coll_ovf_kept", {15'd0, d[0]}, 16'd1);

        // reset mid-count
        do_reset();
        check_reset_view("midreset");

        // prescale + one-shot: reload 1, presc 2
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h01);
        bus_write(3'd2, 8'h02);
        bus_write(3'd0, 8'h05);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            peek(3'd1, d);
            check($sformatf("os_pre%0d", i), {8'h00, d}, 16'h0002);
        end
        @(posedge clk); #1;
        peek(3'd1, d);
        check("os_status", {8'h00, d}, 16'h0001);
        peek(3'd0, d);
        check("os_ctrl", {8'h00, d}, 16'h0004);
        bus_read(3'd5, d);
        check("os_count_h", {8'h00, d}, 16'h0000);
        peek(3'd6, d);
        check("os_count_l", {8'h00, d}, 16'h0001);
        bus_write(3'd1, 8'h01);
        repeat (20) @(posedge clk);
        #1 peek(3'd1, d);
        check("os_no_more", {8'h00, d}, 16'h0000);
        check("os_irq", {15'd0, irq}, 16'd0);

        // atomic reload while running
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h03);
        bus_write(3'd0, 8'h03);
        repeat (5) @(posedge clk);
        bus_write(3'd3, 8'h12);
        peek(3'd3, d);
        check("atom_hold_hidden", {8'h00, d}, 16'h0000);
        bus_write(3'd4, 8'h34);
        peek(3'd3, d);
        check("atom_reload_h", {8'h00, d}, 16'h0012);
        bus_write(3'd1, 8'h01);
        n = 0;
        peek(3'd1, d);
        while (!d[0] && n < 10) begin
            @(posedge clk); #1;
            peek(3'd1, d);
            n++;
        end
        check("atom_first_ovf", {15'd0, d[0]}, 16'd1);
        exp_q.push_back(16'h1235);
        bus_write(3'd1, 8'h01);
        gap = 1;
        peek(3'd1, d);
        while (!d[0] && gap < 6000) begin
            @(posedge clk); #1;
            peek(3'd1, d);
            gap++;
        end
        check("atom_period", 16'(gap), exp_q.pop_front());

        // coherent COUNT_H / COUNT_L read
        bus_write(3'd0, 8'h00);
        bus_write(3'd3, 8'h01);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h01);
        bus_read(3'd5, d);
        check("coh_high", {8'h00, d}, 16'h0001);
        repeat (2) @(posedge clk);
        bus_read(3'd6, d);
        check("coh_shadow", {8'h00, d}, 16'h0000);

        // randomized periodic runs against the arithmetic model
        for (int trial = 0; trial < 8; trial++) begin
            r = $urandom_range(0, 150);
            p = $urandom_range(0, 3);
            per = (r + 1) * (p + 1);
            bus_write(3'd0, 8'h00);
            bus_write(3'd1, 8'h01);
            bus_write(3'd2, 8'(p));
            bus_write(3'd3, 8'(r >> 8));
            bus_write(3'd4, 8'(r));
            bus_write(3'd0, 8'h03);
            for (int k = 0; k < 2 * per + 4; k++) begin
                cs = 1'b1; rw = 1'b1;
                if (k % 2 == 0) begin
                    AD = 3'd5;
                    #1 c = model_count(r, p, k);
                    check($sformatf("rnd%0d_hi_k%0d", trial, k), {8'h00, DO}, {8'h00, c[15:8]});
                end else begin
                    AD = 3'd6;
                    #1 c = model_count(r, p, k - 1);
                    check($sformatf("rnd%0d_lo_k%0d", trial, k), {8'h00, DO}, {8'h00, c[7:0]});
                end
                check($sformatf("rnd%0d_irq_k%0d", trial, k), {15'd0, irq}, {15'd0, k >= per});
                @(posedge clk); #1;
            end
            cs = 1'b0;
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
